// File: rtl/bcd_conv_pkg.sv
// rtl/bcd_conv_pkg.sv - shared types and constants for the BCD-to-binary converter
// Purpose: FSM state enum and digit-level constants used by the converter and
//          its per-digit adjust cell.
package bcd_conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int         DIGIT_W    = 4;
  // After a right shift, a digit >= 8 holds a carried-in half-ten (8 instead
  // of 5); subtracting 3 restores the correct BCD weight.
  localparam logic [3:0] ADJ_THRESH = 4'd8;
  localparam logic [3:0] ADJ_VAL    = 4'd3;
  localparam logic [3:0] MAX_DIGIT  = 4'd9;

endpackage

// File: rtl/bcd_digit_adjust.sv
// rtl/bcd_digit_adjust.sv - per-digit correction step of reverse double-dabble
// Purpose: combinational d_out = (d_in >= 8) ? d_in - 3 : d_in.
// Ports:
//   d_in   in  DIGIT_W  BCD digit after the work-register shift
//   d_out  out DIGIT_W  corrected digit
module bcd_digit_adjust
  import bcd_conv_pkg::*;
(
  input  logic [DIGIT_W-1:0] d_in,
  output logic [DIGIT_W-1:0] d_out
);

  assign d_out = (d_in >= ADJ_THRESH) ? (d_in - ADJ_VAL) : d_in;

endmodule

// File: rtl/bcd4_to_bin_converter.sv
// rtl/bcd4_to_bin_converter.sv - sequential packed-BCD to unsigned binary converter
// Purpose: reverse double-dabble, one shift/adjust iteration per clock,
//          start/busy/done handshake, one result per accepted request.
// Optional feature: macro BCD_INPUT_CHECK_EN enables invalid-digit detection
//          (digit > 9 short-circuits to DONE with err=1 and bin_out unchanged).
// Ports:
//   clk      in   1          rising-edge clock
//   reset    in   1          synchronous active-high reset
//   start    in   1          request, sampled only in IDLE
//   bcd_in   in   4*DIGITS   packed BCD, digit0 in [3:0]
//   busy     out  1          conversion in progress
//   done     out  1          one-cycle pulse, bin_out/err valid
//   bin_out  out  BIN_W      result, held until next done
//   err      out  1          invalid-digit flag (0 unless BCD_INPUT_CHECK_EN)
module bcd4_to_bin_converter
  import bcd_conv_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [DIGITS*DIGIT_W-1:0]   bcd_in,
  output logic                        busy,
  output logic                        done,
  output logic [BIN_W-1:0]            bin_out,
  output logic                        err
);

  localparam int BCD_W  = DIGITS * DIGIT_W;
  localparam int WORK_W = 2 * BCD_W;
  localparam int CNT_W  = $clog2(BCD_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BCD_W - 1);

  state_t             state_q, state_d;
  logic [WORK_W-1:0]  work_q, work_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_out_q, bin_out_d;

  // Work register layout: {bcd_part[BCD_W-1:0], bin_part[BCD_W-1:0]}.
  logic [WORK_W-1:0]  shifted;
  logic [BCD_W-1:0]   adj_bcd;
  logic [WORK_W-1:0]  iter_work;

  assign shifted = work_q >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d_in  (shifted[BCD_W + g*DIGIT_W +: DIGIT_W]),
      .d_out (adj_bcd[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign iter_work = {adj_bcd, shifted[BCD_W-1:0]};

`ifdef BCD_INPUT_CHECK_EN
  logic err_q, err_d;
  logic bad_digit;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[i*DIGIT_W +: DIGIT_W] > MAX_DIGIT) bad_digit = 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    bin_out_d = bin_out_q;
`ifdef BCD_INPUT_CHECK_EN
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = {bcd_in, {BCD_W{1'b0}}};
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef BCD_INPUT_CHECK_EN
          if (bad_digit) begin
            state_d = DONE;
            err_d   = 1'b1;
          end
`endif
        end
      end
      SHIFT: begin
        work_d = iter_work;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d   = DONE;
          // Loaded on the final iteration so the value is visible with done.
          // Bits of bin_part above BIN_W are zero for valid input and dropped.
          bin_out_d = iter_work[BIN_W-1:0];
`ifdef BCD_INPUT_CHECK_EN
          err_d     = 1'b0;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      work_q    <= '0;
      cnt_q     <= '0;
      bin_out_q <= '0;
`ifdef BCD_INPUT_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      bin_out_q <= bin_out_d;
`ifdef BCD_INPUT_CHECK_EN
      err_q     <= err_d;
`endif
    end
  end

  assign busy    = (state_q == SHIFT);
  assign done    = (state_q == DONE);
  assign bin_out = bin_out_q;

endmodule

// File: tb/tb_bcd4_to_bin_converter.sv
// tb/tb_bcd4_to_bin_converter.sv - self-checking bench for bcd4_to_bin_converter
module tb_bcd4_to_bin_converter;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] bcd_in;
  logic        busy;
  logic        done;
  logic [13:0] bin_out;
  logic        err;

  int checks;
  int failures;

  bcd4_to_bin_converter #(.DIGITS(4), .BIN_W(14)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: decimal weight of each digit, plain arithmetic.
  function automatic int ref_value(input logic [15:0] b);
    return int'(b[3:0]) + 10 * int'(b[7:4]) + 100 * int'(b[11:8]) + 1000 * int'(b[15:12]);
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // Inputs change on negedge; outputs of cycle k are sampled on the negedge of cycle k.
  task automatic do_conv(input logic [15:0] bcd, input string tag);
    int lat;
    int busy_cnt;
    logic [13:0] res;
    lat = 0;
    busy_cnt = 0;
    res = '0;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = bcd;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start  = 1'b0;
      bcd_in = 16'($urandom);
      if (busy) busy_cnt++;
      if (done) begin
        lat = k;
        res = bin_out;
        check({tag, "_err"}, 32'(err), 32'd0);
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'd17);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd16);
    check({tag, "_bin_out"}, 32'(res), 32'(ref_value(bcd)));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_bin_hold"}, 32'(bin_out), 32'(ref_value(bcd)));
  endtask

  initial begin
    int n_done;
    int done_k [$];
    int done_v [$];
    logic [15:0] rv;

    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b0;
    bcd_in   = 16'h0000;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bin_out", 32'(bin_out), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset = 1'b0;

    // Directed values
    do_conv(16'h0000, "zero");
    do_conv(16'h9999, "max");
    do_conv(16'h1234, "h1234");
    do_conv(16'h0010, "ten");

    // Start pulses during conversion are ignored
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h0042;
    n_done = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      start  = (k == 5 || k == 12);
      bcd_in = 16'h0099;
      if (done) begin
        n_done++;
        check("ignore_done_cycle", 32'(k), 32'd17);
        check("ignore_bin_out", 32'(bin_out), 32'd42);
      end
    end
    check("ignore_done_count", 32'(n_done), 32'd1);

    // Reset in the middle of a conversion
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h0777;
    n_done = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      start = 1'b0;
      reset = (k == 8);
      if (k == 9) begin
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_bin_out", 32'(bin_out), 32'd0);
      end
      if (done) n_done++;
    end
    check("midrst_no_done", 32'(n_done), 32'd0);
    do_conv(16'h0500, "after_rst");

    // Reset and start in the same cycle: reset wins
    @(negedge clk);
    start  = 1'b1;
    reset  = 1'b1;
    bcd_in = 16'h0123;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    check("rst_wins_busy", 32'(busy), 32'd0);
    check("rst_wins_bin_out", 32'(bin_out), 32'd0);
    repeat (20) begin
      @(negedge clk);
      if (done) check("rst_wins_no_done", 32'(done), 32'd0);
    end

    // Back-to-back with start held high
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h0001;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        done_k.push_back(k);
        done_v.push_back(int'(bin_out));
      end
      if (k == 2) bcd_in = 16'h0002;
      if (k >= 35) start = 1'b0;
    end
    check("b2b_done_count", 32'(done_k.size()), 32'd2);
    if (done_k.size() == 2) begin
      check("b2b_first_k", 32'(done_k[0]), 32'd17);
      check("b2b_first_v", 32'(done_v[0]), 32'd1);
      check("b2b_second_k", 32'(done_k[1]), 32'd35);
      check("b2b_second_v", 32'(done_v[1]), 32'd2);
    end

    // Randomized valid BCD against the arithmetic reference
    for (int i = 0; i < 10; i++) begin
      rv = rand_bcd();
      do_conv(rv, "rand");
    end

`ifdef BCD_INPUT_CHECK_EN
    do_conv(16'h0077, "pre_invalid");
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h12A4;
    @(negedge clk);
    start = 1'b0;
    check("invalid_done_cycle1", 32'(done), 32'd1);
    check("invalid_err", 32'(err), 32'd1);
    check("invalid_bin_hold", 32'(bin_out), 32'd77);
    @(negedge clk);
    check("invalid_err_held", 32'(err), 32'd1);
    do_conv(16'h0321, "post_invalid");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
